// File: rtl/warp_wb_arbiter_pkg.sv
// warp_wb_arbiter_pkg
// Shared constants and types for the writeback arbiter slice.
//   - Unit index constants, in the order the issue stage numbers its
//     integer execution units.
//   - Number of register-file write ports and the width of the
//     contention counter.
//   - Register-address width and register count.
package warp_wb_arbiter_pkg;

    // Execution-unit indices (bit position in the valid/ready vectors).
    localparam int WB_UNIT_XARITH0 = 0;
    localparam int WB_UNIT_XARITH1 = 1;
    localparam int WB_UNIT_XLOGIC0 = 2;
    localparam int WB_UNIT_XLOGIC1 = 3;
    localparam int WB_UNIT_XSHIFT  = 4;
    localparam int WB_UNIT_XMULTL  = 5;
    localparam int WB_UNIT_XMULTH  = 6;
    localparam int WB_UNIT_XDIV    = 7;

    localparam int NUM_WB_PORTS = 2;
    localparam int WB_CNT_WIDTH = 16;

    localparam int RD_W     = 5;
    localparam int NUM_REGS = 32;

    typedef logic [RD_W-1:0] rd_t;

endpackage

// File: rtl/warp_wb_arbiter_rr_pick.sv
// warp_rr_pick
// Cyclic first-set-bit finder used for round-robin grants.
// Ports:
//   req   in  N   request mask
//   start in  IW  index where the search begins
//   found out 1   some bit of req is set
//   idx   out IW  first set bit at or after start, wrapping past N-1 to 0
module warp_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest hit is the
    // last one written and therefore wins.
    always_comb begin
        int p;
        p     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            p = int'(start) + i;
            if (p >= N) begin
                p = p - N;
            end
            if (req[p[IW-1:0]]) begin
                found = 1'b1;
                idx   = p[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/warp_wb_arbiter.sv
// warp_wb_arbiter
// Shares the two register-file write ports among the integer execution
// units. Up to two completed results are picked per cycle round-robin;
// the picks are registered onto the write ports and the matching
// reservation bits are pulsed on o_release in the same cycle.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_unit_valid/o_unit_ready  per-unit result handshake (ready is comb)
//   i_unit_rd, i_unit_data     per-unit destination register and result
//   o_wb0_*, o_wb1_*     registered write ports (grant A -> 0, B -> 1)
//   o_release            registered one-cycle reservation clear mask
//   o_contention_cnt     saturating count of cycles with >2 requesters
// Build option: WARP_WB_X0_FILTER_EN -- results targeting x0 are accepted
// immediately without consuming a write port or moving the pointer.
module warp_wb_arbiter
    import warp_wb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 8,
    parameter int XLEN      = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_UNITS-1:0]      i_unit_valid,
    output logic [NUM_UNITS-1:0]      o_unit_ready,
    input  logic [RD_W*NUM_UNITS-1:0] i_unit_rd,
    input  logic [XLEN*NUM_UNITS-1:0] i_unit_data,
    output logic                      o_wb0_en,
    output logic [RD_W-1:0]           o_wb0_addr,
    output logic [XLEN-1:0]           o_wb0_data,
    output logic                      o_wb1_en,
    output logic [RD_W-1:0]           o_wb1_addr,
    output logic [XLEN-1:0]           o_wb1_data,
    output logic [NUM_REGS-1:0]       o_release,
    output logic [WB_CNT_WIDTH-1:0]   o_contention_cnt
);

    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    rd_t                    unit_rd   [NUM_UNITS];
    logic [XLEN-1:0]        unit_data [NUM_UNITS];
    logic [NUM_UNITS-1:0]   req_mask;
    logic [NUM_UNITS-1:0]   x0_mask;
    logic [NUM_UNITS-1:0]   a_onehot;
    logic [NUM_UNITS-1:0]   b_onehot;
    logic [NUM_UNITS-1:0]   b_req;
    logic                   a_found, b_found, b_ok;
    logic [IW-1:0]          a_idx, b_idx;
    logic [IW-1:0]          ptr_reg, ptr_next;
    rd_t                    rd_a, rd_b;
    logic [NUM_REGS-1:0]    release_next;
    logic                   contention;
    logic [WB_CNT_WIDTH-1:0] cnt_reg;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        if (int'(x) == NUM_UNITS - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
        assign unit_rd[gi]   = i_unit_rd[RD_W*gi +: RD_W];
        assign unit_data[gi] = i_unit_data[XLEN*gi +: XLEN];
        assign a_onehot[gi]  = a_found && (a_idx == IW'(gi));
        assign b_onehot[gi]  = b_ok && (b_idx == IW'(gi));
    end

`ifdef WARP_WB_X0_FILTER_EN
    // x0 results are sunk on the spot and hidden from arbitration.
    logic [NUM_UNITS-1:0] rd_zero;
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_x0
        assign rd_zero[gi] = (unit_rd[gi] == '0);
    end
    assign x0_mask  = i_unit_valid & rd_zero;
    assign req_mask = i_unit_valid & ~rd_zero;
`else
    assign x0_mask  = '0;
    assign req_mask = i_unit_valid;
`endif

    warp_rr_pick #(.N(NUM_UNITS), .IW(IW)) u_pick_a (
        .req   (req_mask),
        .start (ptr_reg),
        .found (a_found),
        .idx   (a_idx)
    );

    // Second pick continues the cyclic search just past A.
    assign b_req = req_mask & ~a_onehot;

    warp_rr_pick #(.N(NUM_UNITS), .IW(IW)) u_pick_b (
        .req   (b_req),
        .start (wrap_inc(a_idx)),
        .found (b_found),
        .idx   (b_idx)
    );

    assign rd_a = unit_rd[a_idx];
    assign rd_b = unit_rd[b_idx];

    // Two writes to the same live register in one cycle would have an
    // undefined winner in the register file; hold B back a cycle instead.
    assign b_ok = b_found && !((rd_a == rd_b) && (rd_a != '0));

    assign o_unit_ready = a_onehot | b_onehot | x0_mask;
    assign contention   = ($countones(req_mask) > 2);

    always_comb begin
        ptr_next = ptr_reg;
        if (b_ok) begin
            ptr_next = wrap_inc(b_idx);
        end else if (a_found) begin
            ptr_next = wrap_inc(a_idx);
        end
    end

    // x0 holds no reservation, so its bit is never pulsed.
    always_comb begin
        release_next = '0;
        if (a_found && (rd_a != '0)) begin
            release_next[rd_a] = 1'b1;
        end
        if (b_ok && (rd_b != '0)) begin
            release_next[rd_b] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            o_wb0_en   <= 1'b0;
            o_wb0_addr <= '0;
            o_wb0_data <= '0;
            o_wb1_en   <= 1'b0;
            o_wb1_addr <= '0;
            o_wb1_data <= '0;
            o_release  <= '0;
        end else begin
            ptr_reg    <= ptr_next;
            o_wb0_en   <= a_found;
            o_wb0_addr <= rd_a;
            o_wb0_data <= unit_data[a_idx];
            o_wb1_en   <= b_ok;
            o_wb1_addr <= rd_b;
            o_wb1_data <= unit_data[b_idx];
            o_release  <= release_next;
            if (contention && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_contention_cnt = cnt_reg;

endmodule

// File: tb/tb_warp_wb_arbiter.sv
// tb_warp_wb_arbiter
// Table of directed vectors from reset, a mid-stream reset sequence, then
// randomized traffic checked against a round-robin reference model.
module tb_warp_wb_arbiter;

    localparam int N  = 8;
    localparam int XL = 64;
`ifdef WARP_WB_X0_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid;
    logic [N-1:0]    ready;
    logic [5*N-1:0]  rd_bus;
    logic [XL*N-1:0] data_bus;
    logic            wb0_en, wb1_en;
    logic [4:0]      wb0_addr, wb1_addr;
    logic [XL-1:0]   wb0_data, wb1_data;
    logic [31:0]     rel;
    logic [15:0]     ccnt;

    int checks = 0;
    int errors = 0;

    logic        pend [N];
    logic [4:0]  rdv  [N];
    logic [63:0] datv [N];

    always #5 clk = ~clk;

    warp_wb_arbiter #(.NUM_UNITS(N), .XLEN(XL)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_unit_valid     (valid),
        .o_unit_ready     (ready),
        .i_unit_rd        (rd_bus),
        .i_unit_data      (data_bus),
        .o_wb0_en         (wb0_en),
        .o_wb0_addr       (wb0_addr),
        .o_wb0_data       (wb0_data),
        .o_wb1_en         (wb1_en),
        .o_wb1_addr       (wb1_addr),
        .o_wb1_data       (wb1_data),
        .o_release        (rel),
        .o_contention_cnt (ccnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int u = 0; u < N; u++) begin
            valid[u]           = pend[u];
            rd_bus[5*u +: 5]   = rdv[u];
            data_bus[XL*u +: XL] = datv[u];
        end
    endtask

    function automatic logic [31:0] rel_of(input int a, input int b);
        logic [31:0] r;
        r = '0;
        if (a >= 0 && rdv[a] != 5'd0) r[rdv[a]] = 1'b1;
        if (b >= 0 && rdv[b] != 5'd0) r[rdv[b]] = 1'b1;
        return r;
    endfunction

    // Reference: list the requesters in cyclic order from ptr; the first
    // two are the candidates, the second dropped on a live-rd clash.
    task automatic model(input int p, output int a, output int b,
                         output int nreq, output logic [7:0] rdy);
        int order[$];
        int u;
        for (int k = 0; k < N; k++) begin
            u = (p + k) % N;
            if (pend[u] && (!FILTER || rdv[u] != 5'd0)) order.push_back(u);
        end
        nreq = order.size();
        a = (nreq > 0) ? order[0] : -1;
        b = (nreq > 1) ? order[1] : -1;
        if (b >= 0 && rdv[a] == rdv[b] && rdv[a] != 5'd0) b = -1;
        rdy = '0;
        if (a >= 0) rdy[a] = 1'b1;
        if (b >= 0) rdy[b] = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (FILTER && pend[k] && rdv[k] == 5'd0) rdy[k] = 1'b1;
        end
    endtask

    function automatic logic [39:0] rd_def();
        logic [39:0] r;
        for (int u = 0; u < N; u++) r[5*u +: 5] = 5'(8 + u);
        return r;
    endfunction

    function automatic logic [39:0] set_rd(input logic [39:0] base, input int u, input logic [4:0] v);
        logic [39:0] r;
        r = base;
        r[5*u +: 5] = v;
        return r;
    endfunction

    typedef struct {
        logic [7:0]  valid;
        logic [39:0] rd;
        logic [7:0]  ready;
        int          a;
        int          b;
    } vec_t;

    vec_t vecs [12];

    int          exp_cnt, mptr, mcnt, ma, mb, nreq, tn;
    logic [7:0]  exp_rdy;
    logic        q_en0, q_en1;
    logic [4:0]  q_addr0, q_addr1;
    logic [63:0] q_data0, q_data1;
    logic [31:0] q_rel;

    initial begin
        // From reset, pointer starts at 0; expectations hand-derived.
        vecs[0]  = '{8'h10, set_rd(rd_def(), 4, 5'd7), 8'h10, 4, -1};           // single xshift
        vecs[1]  = '{8'h00, rd_def(), 8'h00, -1, -1};                           // idle, ptr holds 5
        vecs[2]  = '{8'h03, set_rd(set_rd(rd_def(), 0, 5'd5), 1, 5'd5), 8'h01, 0, -1}; // same rd
        vecs[3]  = '{8'h02, set_rd(rd_def(), 1, 5'd5), 8'h02, 1, -1};           // deferred unit 1
        vecs[4]  = '{8'hFF, rd_def(), 8'h0C, 2, 3};
        vecs[5]  = '{8'hF3, rd_def(), 8'h30, 4, 5};
        vecs[6]  = '{8'hC3, rd_def(), 8'hC0, 6, 7};
        vecs[7]  = '{8'h03, rd_def(), 8'h03, 0, 1};
        vecs[8]  = '{8'h40, rd_def(), 8'h40, 6, -1};                            // ptr -> 7
        vecs[9]  = '{8'h81, rd_def(), 8'h81, 7, 0};                             // wrap
        vecs[10] = '{8'h04, set_rd(rd_def(), 2, 5'd0), 8'h04, FILTER ? -1 : 2, -1}; // x0 result
        vecs[11] = '{8'h00, rd_def(), 8'h00, -1, -1};

        for (int u = 0; u < N; u++) begin
            pend[u] = 1'b0; rdv[u] = '0; datv[u] = '0;
        end
        drive();
        rst = 1'b1;
        #2;
        chk("reset_wb0_en", 64'(wb0_en), 64'(0));
        chk("reset_wb1_en", 64'(wb1_en), 64'(0));
        chk("reset_release", 64'(rel), 64'(0));
        chk("reset_cnt", 64'(ccnt), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 12; i++) begin
            for (int u = 0; u < N; u++) begin
                pend[u] = vecs[i].valid[u];
                rdv[u]  = vecs[i].rd[5*u +: 5];
                datv[u] = 64'h1230 + 64'(u);
            end
            drive();
            tn = 0;
            for (int u = 0; u < N; u++) if (pend[u] && (!FILTER || rdv[u] != 5'd0)) tn++;
            if (tn > 2) exp_cnt++;
            #3;
            chk($sformatf("vec%0d_ready", i), 64'(ready), 64'(vecs[i].ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_wb0_en", i), 64'(wb0_en), 64'(vecs[i].a >= 0));
            if (vecs[i].a >= 0) begin
                chk($sformatf("vec%0d_wb0_addr", i), 64'(wb0_addr), 64'(rdv[vecs[i].a]));
                chk($sformatf("vec%0d_wb0_data", i), wb0_data, 64'h1230 + 64'(vecs[i].a));
            end
            chk($sformatf("vec%0d_wb1_en", i), 64'(wb1_en), 64'(vecs[i].b >= 0));
            if (vecs[i].b >= 0) begin
                chk($sformatf("vec%0d_wb1_addr", i), 64'(wb1_addr), 64'(rdv[vecs[i].b]));
                chk($sformatf("vec%0d_wb1_data", i), wb1_data, 64'h1230 + 64'(vecs[i].b));
            end
            chk($sformatf("vec%0d_release", i), 64'(rel), 64'(rel_of(vecs[i].a, vecs[i].b)));
            chk($sformatf("vec%0d_cnt", i), 64'(ccnt), 64'(exp_cnt));
            $display("vec %0d valid=%h ready=%h wb0=%b@%0d wb1=%b@%0d rel=%h cnt=%0d",
                     i, vecs[i].valid, ready, wb0_en, wb0_addr, wb1_en, wb1_addr, rel, ccnt);
        end

        // ---------------- reset mid-stream ----------------
        for (int u = 0; u < N; u++) begin
            pend[u] = 1'b1; rdv[u] = 5'(8 + u); datv[u] = 64'h1230 + 64'(u);
        end
        drive();
        @(posedge clk); #1;
        chk("midrst_pre_wb0_en", 64'(wb0_en), 64'(1));
        chk("midrst_pre_cnt", 64'(ccnt), 64'(exp_cnt + 1));
        rst = 1'b1;
        for (int u = 0; u < N; u++) pend[u] = 1'b0;
        drive();
        #1;
        chk("midrst_wb0_en", 64'(wb0_en), 64'(0));
        chk("midrst_wb1_en", 64'(wb1_en), 64'(0));
        chk("midrst_release", 64'(rel), 64'(0));
        chk("midrst_cnt", 64'(ccnt), 64'(0));
        chk("midrst_ready", 64'(ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        // Pointer must be back at 0: units 0 and 7 give A=0, B=7.
        pend[0] = 1'b1; pend[7] = 1'b1;
        drive();
        #3;
        chk("postrst_ready", 64'(ready), 64'(8'h81));
        @(posedge clk); #1;
        chk("postrst_wb0_addr", 64'(wb0_addr), 64'(8));
        chk("postrst_wb1_addr", 64'(wb1_addr), 64'(15));
        $display("midrst wb0=%b@%0d wb1=%b@%0d", wb0_en, wb0_addr, wb1_en, wb1_addr);

        // ---------------- randomized traffic ----------------
        rst = 1'b1;
        for (int u = 0; u < N; u++) pend[u] = 1'b0;
        drive();
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0; mcnt = 0;
        q_en0 = 1'b0; q_en1 = 1'b0; q_addr0 = '0; q_addr1 = '0;
        q_data0 = '0; q_data1 = '0; q_rel = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 9) < 7) begin
                    pend[u] = 1'b1;
                    rdv[u]  = 5'($urandom_range(0, 31));
                    datv[u] = {$urandom, $urandom};
                end
            end
            drive();
            #3;
            model(mptr, ma, mb, nreq, exp_rdy);
            chk("rnd_ready", 64'(ready), 64'(exp_rdy));
            chk("rnd_wb0_en", 64'(wb0_en), 64'(q_en0));
            chk("rnd_wb1_en", 64'(wb1_en), 64'(q_en1));
            if (q_en0) begin
                chk("rnd_wb0_addr", 64'(wb0_addr), 64'(q_addr0));
                chk("rnd_wb0_data", wb0_data, q_data0);
            end
            if (q_en1) begin
                chk("rnd_wb1_addr", 64'(wb1_addr), 64'(q_addr1));
                chk("rnd_wb1_data", wb1_data, q_data1);
            end
            chk("rnd_release", 64'(rel), 64'(q_rel));
            chk("rnd_cnt", 64'(ccnt), 64'(mcnt));
            q_en0 = (ma >= 0);
            q_en1 = (mb >= 0);
            if (ma >= 0) begin q_addr0 = rdv[ma]; q_data0 = datv[ma]; end
            if (mb >= 0) begin q_addr1 = rdv[mb]; q_data1 = datv[mb]; end
            q_rel = rel_of(ma, mb);
            if (mb >= 0) mptr = (mb + 1) % N;
            else if (ma >= 0) mptr = (ma + 1) % N;
            if (nreq > 2 && mcnt != 16'hFFFF) mcnt++;
            @(posedge clk); #1;
            for (int u = 0; u < N; u++) if (exp_rdy[u]) pend[u] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_wb_arbiter.md
# warp_wb_arbiter

The writeback arbiter shares the register file's two write ports among the eight integer execution units that the issue stage dispatches to. Each cycle it picks up to two completed results with a round-robin policy. It registers the picks onto the write ports. In the same cycle it pulses the matching destination bits so issue can clear its reservation register. It sits between the execution-unit outputs and the register file, and it closes the reservation loop that issue opens at dispatch.

## Interface
Parameters:
- NUM_UNITS, 8, number of result requesters (unit index order: xarith0, xarith1, xlogic0, xlogic1, xshift, xmultl, xmulth, xdiv)
- XLEN, 64, result data width

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_unit_valid  in  NUM_UNITS  result pending, bit per unit
- o_unit_ready  out  NUM_UNITS  result accepted this cycle, bit per unit
- i_unit_rd  in  5*NUM_UNITS  destination register, unit u at [5u+4:5u]
- i_unit_data  in  XLEN*NUM_UNITS  result, unit u at [XLEN*u+XLEN-1:XLEN*u]
- o_wb0_en, o_wb1_en  out  1  write port enable
- o_wb0_addr, o_wb1_addr  out  5  write port address
- o_wb0_data, o_wb1_data  out  XLEN  write port data
- o_release  out  32  reservation clear mask, one-cycle pulse per written rd
- o_contention_cnt  out  16  saturating count of cycles with more than two requesters

## Operation
- Handshake: a result transfers when valid and ready are both high. After raising valid, a unit holds valid, rd and data stable until ready. o_unit_ready is combinational from i_unit_valid and state.
- Round-robin pointer ptr (3 bits, reset 0):
  - grant A = first valid unit at or after ptr, cyclically.
  - grant B = first valid unit after A, cyclically, excluding A.
  - When at least one grant is made, ptr moves to one past the last grant (B if present, else A), modulo NUM_UNITS. Otherwise ptr holds.
- Defensive rule: if A and B carry the same nonzero rd, B is not granted in that cycle. Issue's reservation makes this a protocol violation.
- Port mapping: A drives port 0 and B drives port 1, registered. With only one grant, port 1 enable is 0.
- o_release: registered. Bit rd is set for each granted write with rd != 0. Bit 0 is never set.
- o_contention_cnt increments when popcount(i_unit_valid) > 2 and saturates at 16'hFFFF.
- Reset values: every output 0, ptr 0, counter 0. Reset asserted mid-operation discards the registered writes in flight. Units must also be reset.

## Timing
- Latency from accept to write: 1 cycle. Handshake in cycle N gives o_wbX_en and o_release in cycle N+1.
- Throughput: up to 2 results per cycle, with no bubbles between consecutive grants.
- Fairness: under full load every unit is granted at least once every ceil(NUM_UNITS/2) = 4 cycles.
- Boundary cases:
  - ptr wraps from 7 to 0.
  - A single valid unit is always granted to port 0 in the cycle it is valid, whatever ptr is.
  - No requester: outputs deassert next cycle and ptr holds.

## Configuration
- WARP_WB_X0_FILTER_EN, when defined:
  - Results with rd == 0 get ready the cycle they are valid.
  - They consume no write port, are not counted as requesters, and never appear on o_wbX.
  - ptr ignores them.
- Without the macro, rd == 0 results arbitrate like any other and drive o_wbX_en with address 0. The register file discards them. o_release bit 0 stays 0 in both builds.

## Structure
- warp_defines.v gets:
  - Unit index constants `WB_UNIT_XARITH0 … `WB_UNIT_XDIV.
  - `NUM_WB_PORTS (2).
  - `WB_CNT_WIDTH (16).
- Sub-module warp_rr_pick: given a request mask and start index, returns found and the index of the first set bit at or after start, cyclically. It is instantiated twice: for A, and for B with A masked out and start = A+1.

## Test plan
- Single request: only xshift (unit 4) valid, rd=7, data=0x1234 → ready[4] in same cycle; next cycle wb0_en=1, addr=7, data=0x1234, wb1_en=0, release=1<<7.
- Full load: all 8 units continuously valid with distinct rd → grants (0,1),(2,3),(4,5),(6,7),(0,1). Contention count increments each cycle and each unit is written once per 4 cycles.
- Wrap: ptr=7, units 7 and 0 valid → port0=unit7, port1=unit0, ptr becomes 1.
- Same-rd violation: units 0 and 1 both valid with rd=5 → only unit 0 granted, unit 1 granted next cycle.
- Reset mid-stream: assert i_rst while grants are registered → all outputs 0 immediately, ptr=0, counter=0.
- x0 result: unit 2 valid with rd=0 → with WARP_WB_X0_FILTER_EN: ready same cycle, no wb enable, release=0. Without the macro: wb0_en=1, addr=0, release=0.
